// File: rtl/letter_stream_if.sv
// Letter write stream bundle: classifier guesses and clear request in,
// text_display write strobes and status out.
interface letter_stream_if #(
  parameter int CURSOR_W = 10
);
  logic                guess_valid_in;
  logic [4:0]          guess_in;
  logic                clear_in;
  logic                data_valid_out;
  logic [4:0]          data_out;
  logic [CURSOR_W-1:0] cursor_out;
  logic                fifo_full_out;
  logic                busy_out;
  logic [7:0]          drop_count_out;

  modport master (
    input  guess_valid_in, guess_in, clear_in,
    output data_valid_out, data_out, cursor_out, fifo_full_out, busy_out, drop_count_out
  );

  modport slave (
    output guess_valid_in, guess_in, clear_in,
    input  data_valid_out, data_out, cursor_out, fifo_full_out, busy_out, drop_count_out
  );
endinterface

// File: rtl/letter_stream_tx.sv
// Debounces a per-cycle letter classifier into committed letters, buffers them,
// and emits spaced single-cycle writes plus full-screen clear bursts.
module letter_stream_tx #(
  parameter int         STABLE_CYCLES = 16,
  parameter int         GAP_CYCLES    = 4,
  parameter int         FIFO_DEPTH    = 8,
  parameter int         SCREEN_CHARS  = 1024,
  parameter logic [4:0] NONE_CODE     = 5'd31
) (
  input  logic              clk_in,
  input  logic              rst_in,
  letter_stream_if.master   stream
);
  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CUR_W = $clog2(SCREEN_CHARS);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, CLEAR} state_t;

  // ---------------- stability filter ----------------
  logic [4:0]       cand_reg;
  logic [4:0]       last_reg;
  logic [RUN_W-1:0] run_reg;
  logic             same_guess;
  logic             commit;
  logic             push_req;

  assign same_guess = stream.guess_valid_in && (stream.guess_in == cand_reg);
  assign commit     = same_guess && (run_reg == RUN_W'(STABLE_CYCLES - 1));
  assign push_req   = commit && (cand_reg != NONE_CODE) && (cand_reg != last_reg);

  // last_reg simply follows every commit: NONE re-arms, a repeat leaves it unchanged
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cand_reg <= NONE_CODE;
      last_reg <= NONE_CODE;
      run_reg  <= '0;
    end else if (stream.guess_valid_in) begin
      if (same_guess) begin
        if (run_reg != RUN_W'(STABLE_CYCLES))
          run_reg <= run_reg + RUN_W'(1);
      end else begin
        cand_reg <= stream.guess_in;
        run_reg  <= RUN_W'(1);
      end
      if (commit)
        last_reg <= cand_reg;
    end
  end

  // ---------------- letter FIFO ----------------
  logic [4:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full_reg;
  logic [7:0]       drop_reg;
  logic             fifo_full;
  logic             push_ok;
  logic             pop;
  logic [4:0]       head;

  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign push_ok    = push_req && !fifo_full;
  assign head       = mem[rd_ptr_reg];
  assign count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge clk_in) begin
    if (push_ok)
      mem[wr_ptr_reg] <= cand_reg;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      drop_reg   <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(FIFO_DEPTH));
      if (push_req && fifo_full && (drop_reg != 8'd255))
        drop_reg <= drop_reg + 8'd1;
    end
  end

  // ---------------- output FSM ----------------
  state_t           state_reg, state_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [CUR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic [CUR_W-1:0] cursor_reg, cursor_next;
  logic             pending_reg, pending_next;
  logic             dv_reg, dv_next;
  logic [4:0]       data_reg, data_next;
  logic             busy_reg, busy_next;
  logic             clr_strobe;
  logic             enter_clear;

  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    clr_cnt_next = clr_cnt_reg;
    pop          = 1'b0;
    clr_strobe   = 1'b0;
    enter_clear  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
          enter_clear  = 1'b1;
        end else if (count_reg != '0) begin
          state_next = SEND;
        end
      end
      SEND: begin
        pop          = 1'b1;
        gap_cnt_next = '0;
        state_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1))
          state_next = IDLE;
        else
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
      end
      CLEAR: begin
        clr_strobe = 1'b1;
        if (clr_cnt_reg == CUR_W'(SCREEN_CHARS - 1))
          state_next = IDLE;
        else
          clr_cnt_next = clr_cnt_reg + CUR_W'(1);
      end
      default: state_next = IDLE;
    endcase

    // a clear request landing on the entry edge is absorbed by that burst
    pending_next = pending_reg;
    if (enter_clear)
      pending_next = 1'b0;
    else if (stream.clear_in && (state_reg != CLEAR))
      pending_next = 1'b1;

    dv_next     = pop | clr_strobe;
    data_next   = pop ? head : 5'd0;
    busy_next   = clr_strobe;
    cursor_next = cursor_reg + CUR_W'(dv_next);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= '0;
      clr_cnt_reg <= '0;
      cursor_reg  <= '0;
      pending_reg <= 1'b0;
      dv_reg      <= 1'b0;
      data_reg    <= '0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
      clr_cnt_reg <= clr_cnt_next;
      cursor_reg  <= cursor_next;
      pending_reg <= pending_next;
      dv_reg      <= dv_next;
      data_reg    <= data_next;
      busy_reg    <= busy_next;
    end
  end

  assign stream.data_valid_out = dv_reg;
  assign stream.data_out       = data_reg;
  assign stream.cursor_out     = cursor_reg;
  assign stream.fifo_full_out  = full_reg;
  assign stream.busy_out       = busy_reg;
  assign stream.drop_count_out = drop_reg;
endmodule

// File: tb/tb_letter_stream_tx.sv
// Bench for letter_stream_tx: guess-sequence table plus hand-written clear,
// overflow and reset sequences, checked through a write scoreboard.
module tb_letter_stream_tx;
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  letter_stream_if sif ();

  letter_stream_tx #(
    .STABLE_CYCLES(16), .GAP_CYCLES(4), .FIFO_DEPTH(8),
    .SCREEN_CHARS(1024), .NONE_CODE(5'd31)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .stream (sif.master)
  );

  typedef struct {
    logic [4:0] data;
    logic [9:0] cursor;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [4:0] guess;
    logic       valid;
    int         cycles;
    logic       write;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[15];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cursor = 0;
  int   cyc = 0;
  int   n_strobes = 0;
  int   last_cyc = 0;
  bit   prev_letter = 0;
  bit   prev_busy = 0;
  int   burst_len = 0;

  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in) begin
      if (sif.data_valid_out) begin
        n_strobes++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: actual data=%0d cursor=%0d required no write",
                   sif.data_out, sif.cursor_out);
        end else begin
          e = sb_q.pop_front();
          check("data", int'(sif.data_out), int'(e.data));
          check("cursor", int'(sif.cursor_out), int'(e.cursor));
          check("busy", int'(sif.busy_out), int'(e.busy));
          if (e.busy) begin
            if (prev_busy) check("burst_back_to_back", cyc - last_cyc, 1);
            burst_len = prev_busy ? burst_len + 1 : 1;
            if (burst_len == 1024)
              $display("clear burst done: 1024 writes, cursor=%0d", sif.cursor_out);
          end else begin
            if (prev_letter) check("gap_at_least_5", int'((cyc - last_cyc) >= 5), 1);
            $display("write: data=%0d cursor=%0d cycle=%0d", sif.data_out, sif.cursor_out, cyc);
          end
          prev_letter = !e.busy;
          prev_busy   = e.busy;
          last_cyc    = cyc;
        end
      end else begin
        check("data_zero_when_idle", int'(sif.data_out), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] d, input logic b);
    exp_t e;
    exp_cursor = (exp_cursor + 1) % 1024;
    e.data   = d;
    e.cursor = 10'(exp_cursor);
    e.busy   = b;
    sb_q.push_back(e);
  endtask

  task automatic push_clear();
    repeat (1024) push_exp(5'd0, 1'b1);
  endtask

  task automatic apply_seg(input logic [4:0] g, input logic v, input int n, input logic w);
    if (w) push_exp(g, 1'b0);
    sif.clear_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      sif.guess_valid_in = v;
      sif.guess_in       = g;
      step();
    end
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    sif.guess_valid_in = 1'b0;
    while (sb_q.size() != 0 && i < budget) begin
      step();
      i++;
    end
    check("drain_remaining", sb_q.size(), 0);
    sb_q.delete();
    repeat (20) step();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    sb_q.delete();
    exp_cursor  = 0;
    prev_letter = 0;
    prev_busy   = 0;
    step();
    step();
    rst_in = 1'b0;
    step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dv"}, int'(sif.data_valid_out), 0);
    check({tag, "_data"}, int'(sif.data_out), 0);
    check({tag, "_cursor"}, int'(sif.cursor_out), 0);
    check({tag, "_full"}, int'(sif.fifo_full_out), 0);
    check({tag, "_busy"}, int'(sif.busy_out), 0);
    check({tag, "_drop"}, int'(sif.drop_count_out), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strobes_before;
    vecs[0]  = '{5'd31, 1'b1, 16, 1'b0};
    vecs[1]  = '{5'd5,  1'b1, 40, 1'b1};
    vecs[2]  = '{5'd31, 1'b1, 16, 1'b0};
    vecs[3]  = '{5'd5,  1'b1, 16, 1'b1};
    vecs[4]  = '{5'd31, 1'b1, 16, 1'b0};
    vecs[5]  = '{5'd5,  1'b1, 16, 1'b1};
    vecs[6]  = '{5'd31, 1'b1, 16, 1'b0};
    vecs[7]  = '{5'd5,  1'b1, 15, 1'b0};
    vecs[8]  = '{5'd7,  1'b1, 1,  1'b0};
    vecs[9]  = '{5'd5,  1'b1, 15, 1'b0};
    vecs[10] = '{5'd31, 1'b1, 16, 1'b0};
    vecs[11] = '{5'd5,  1'b1, 8,  1'b0};
    vecs[12] = '{5'd5,  1'b0, 50, 1'b0};
    vecs[13] = '{5'd5,  1'b1, 8,  1'b1};
    vecs[14] = '{5'd31, 1'b1, 16, 1'b0};

    rst_in = 1'b1;
    sif.guess_valid_in = 1'b0;
    sif.guess_in       = 5'd0;
    sif.clear_in       = 1'b0;
    repeat (3) step();
    check_outputs_zero("reset");
    rst_in = 1'b0;
    step();

    // single commit and its latency
    apply_seg(5'd5, 1'b1, 16, 1'b1);
    sif.guess_valid_in = 1'b0;
    check("lat_edge_k_dv", int'(sif.data_valid_out), 0);
    step();
    check("lat_edge_k1_dv", int'(sif.data_valid_out), 0);
    step();
    check("lat_edge_k2_dv", int'(sif.data_valid_out), 1);
    check("lat_edge_k2_data", int'(sif.data_out), 5);
    check("lat_edge_k2_cursor", int'(sif.cursor_out), 1);
    wait_drain(100);

    // repeats, noise and valid gaps
    for (int i = 0; i < 15; i++)
      apply_seg(vecs[i].guess, vecs[i].valid, vecs[i].cycles, vecs[i].write);
    wait_drain(200);

    // overflow while a clear burst holds the output back
    sif.guess_valid_in = 1'b0;
    sif.clear_in = 1'b1;
    push_clear();
    step();
    sif.clear_in = 1'b0;
    for (int l = 1; l <= 10; l++) begin
      apply_seg(5'(l), 1'b1, 16, l <= 8);
      if (l == 7) check("full_at_7", int'(sif.fifo_full_out), 0);
      if (l == 8) begin
        check("full_at_8", int'(sif.fifo_full_out), 1);
        check("drop_at_8", int'(sif.drop_count_out), 0);
      end
    end
    check("full_after_10", int'(sif.fifo_full_out), 1);
    check("drop_after_10", int'(sif.drop_count_out), 2);
    check("busy_during_overflow", int'(sif.busy_out), 1);
    wait_drain(3000);
    check("full_after_drain", int'(sif.fifo_full_out), 0);

    // clear with a pending letter from cursor 3, second clear ignored
    do_reset();
    apply_seg(5'd1, 1'b1, 16, 1'b1);
    apply_seg(5'd2, 1'b1, 16, 1'b1);
    apply_seg(5'd3, 1'b1, 16, 1'b1);
    wait_drain(200);
    check("cursor_before_clear", int'(sif.cursor_out), 3);
    apply_seg(5'd9, 1'b1, 15, 1'b0);
    push_clear();
    push_exp(5'd9, 1'b0);
    sif.guess_in = 5'd9;
    sif.guess_valid_in = 1'b1;
    sif.clear_in = 1'b1;
    step();
    sif.clear_in = 1'b0;
    sif.guess_valid_in = 1'b0;
    repeat (300) step();
    check("busy_mid_burst", int'(sif.busy_out), 1);
    sif.clear_in = 1'b1;
    step();
    sif.clear_in = 1'b0;
    wait_drain(3000);
    check("cursor_after_clear_letter", int'(sif.cursor_out), 4);
    check("busy_after_burst", int'(sif.busy_out), 0);

    // asynchronous reset in the middle of a clear burst
    sif.clear_in = 1'b1;
    push_clear();
    step();
    sif.clear_in = 1'b0;
    repeat (100) step();
    check("busy_before_reset", int'(sif.busy_out), 1);
    #2;
    rst_in = 1'b1;
    sb_q.delete();
    exp_cursor  = 0;
    prev_letter = 0;
    prev_busy   = 0;
    #1;
    check_outputs_zero("midreset");
    step();
    step();
    rst_in = 1'b0;
    strobes_before = n_strobes;
    repeat (200) step();
    check("strobes_after_reset", n_strobes - strobes_before, 0);
    check("busy_after_reset", int'(sif.busy_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
